// File: rtl/psum_accum_relu_quant_if.sv
// Streaming port bundle between the MAC array, the partial-sum accumulator
// and the write-back stage.
interface psum_accum_relu_quant_if #(
  parameter int PSUM_W = 18,
  parameter int ACC_W  = 24
);
  logic                     start;
  logic signed [ACC_W-1:0]  bias;
  logic                     valid_in;
  logic signed [PSUM_W-1:0] din;
  logic                     valid_out;
  logic signed [7:0]        dout;
  logic                     busy;
  logic                     done;

  modport master (
    output start, bias, valid_in, din,
    input  valid_out, dout, busy, done
  );

  modport slave (
    input  start, bias, valid_in, din,
    output valid_out, dout, busy, done
  );
endinterface

// File: rtl/psum_accum_relu_quant.sv
// Cross-channel partial-sum accumulator with bias, ReLU and
// round/shift/saturate requantisation to INT8.
module psum_accum_relu_quant #(
  parameter int PSUM_W  = 18,
  parameter int ACC_W   = 24,
  parameter int PIX_NUM = 100,
  parameter int CH_NUM  = 3,
  parameter int SHIFT   = 8,
  parameter int ADDR_W  = 7
) (
  input logic clk,
  input logic rst,
  psum_accum_relu_quant_if.slave bus
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_NUM - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);
  localparam logic [ACC_W+1:0] RND = (ACC_W + 2)'(1) << (SHIFT - 1);
  localparam logic [ACC_W+1:0] QMAX = (ACC_W + 2)'(127);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic signed [ACC_W-1:0] bias_r;
  logic valid_out_r;
  logic [7:0] dout_r;
  logic busy_r;
  logic done_r;

  logic signed [ACC_W-1:0] mem [PIX_NUM];

  logic beat;
  logic first_ch;
  logic last_ch;
  logic last_pix;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] rd;
  logic signed [ACC_W-1:0] part;
  logic signed [ACC_W:0] sum;
  logic [ACC_W:0] relu;
  logic [ACC_W+1:0] rnd;
  logic [ACC_W+1:0] q;
  logic [7:0] sat;

  always_comb begin
    beat = (state == ACC) && bus.valid_in;
    first_ch = (ch_cnt == '0);
    last_ch = (ch_cnt == CH_LAST);
    last_pix = (pix_cnt == PIX_LAST);
    din_ext = {{(ACC_W - PSUM_W){bus.din[PSUM_W-1]}}, bus.din};
    rd = mem[pix_cnt];
    // single-channel maps never write the buffer, so it must not be read
    part = (CH_NUM == 1) ? '0 : rd;
    sum = {part[ACC_W-1], part}
        + {din_ext[ACC_W-1], din_ext}
        + {bias_r[ACC_W-1], bias_r};
    relu = sum[ACC_W] ? '0 : $unsigned(sum);
    rnd = {1'b0, relu} + RND;
    q = rnd >> SHIFT;
    sat = (q > QMAX) ? 8'd127 : q[7:0];
  end

  always_ff @(posedge clk) begin
    if (beat && !last_ch) begin
      mem[pix_cnt] <= first_ch ? din_ext : rd + din_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix_cnt <= '0;
      ch_cnt <= '0;
      bias_r <= '0;
      valid_out_r <= 1'b0;
      dout_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      valid_out_r <= 1'b0;
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ACC;
            busy_r <= 1'b1;
            bias_r <= bus.bias;
            pix_cnt <= '0;
            ch_cnt <= '0;
          end
        end
        ACC: begin
          if (bus.valid_in) begin
            if (last_ch) begin
              valid_out_r <= 1'b1;
              dout_r <= sat;
            end
            if (last_pix) begin
              pix_cnt <= '0;
              if (last_ch) begin
                ch_cnt <= '0;
                state <= IDLE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_out = valid_out_r;
  assign bus.dout = dout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_psum_accum_relu_quant.sv
// Scoreboard bench for psum_accum_relu_quant with a 4-pixel, 3-channel map.
module tb_psum_accum_relu_quant;
  localparam int PSUM_W = 18;
  localparam int ACC_W = 24;
  localparam int PIX = 4;
  localparam int CH = 3;
  localparam int SHIFT = 8;
  localparam int BEATS = PIX * CH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  psum_accum_relu_quant_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

  psum_accum_relu_quant #(
    .PSUM_W(PSUM_W), .ACC_W(ACC_W), .PIX_NUM(PIX),
    .CH_NUM(CH), .SHIFT(SHIFT), .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stim [BEATS];
  logic [8:0] exp_q [$];
  logic [8:0] e;

  function automatic logic [8:0] model(input int s, input bit last);
    int r;
    r = (s < 0) ? 0 : s;
    r = (r + (1 << (SHIFT - 1))) >>> SHIFT;
    if (r > 127) r = 127;
    return {last, 8'(r)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: dout=%0d done=%0b, none expected",
                   bus.dout, bus.done);
        end else begin
          e = exp_q.pop_front();
          if ({bus.done, bus.dout} !== e) begin
            errors++;
            $display("FAIL out_value: done/dout=%0b/%0d expected %0b/%0d",
                     bus.done, bus.dout, e[8], e[7:0]);
          end
        end
      end else if (bus.done) begin
        checks++;
        errors++;
        $display("FAIL done_alone: done=1 while valid_out=0, expected 0");
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic fill(input int v);
    for (int i = 0; i < BEATS; i++) stim[i] = v;
  endtask

  task automatic run_map(input int b, input bit gaps, input bit junk);
    bus.start = 1'b1;
    bus.bias = ACC_W'(b);
    if (junk) begin
      bus.valid_in = 1'b1;
      bus.din = PSUM_W'(5000);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: busy=%0b expected 1", bus.busy);
    end
    for (int i = 0; i < BEATS; i++) begin
      int ch;
      int px;
      ch = i / PIX;
      px = i % PIX;
      if (gaps) begin
        repeat ($urandom_range(0, 5)) begin
          if (junk) begin
            bus.start = 1'b1;
            bus.bias = ACC_W'(100000);
          end
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
      if (ch == CH - 1) begin
        exp_q.push_back(model(stim[px] + stim[PIX + px] + stim[2 * PIX + px] + b,
                              px == PIX - 1));
      end
      bus.valid_in = 1'b1;
      bus.din = PSUM_W'(stim[i]);
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (ch == CH - 1) begin
        checks++;
        if (bus.valid_out !== 1'b1) begin
          errors++;
          $display("FAIL latency: valid_out=%0b at pixel %0d, expected 1",
                   bus.valid_out, px);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_map: busy=%0b expected 0", bus.busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({bus.valid_out, bus.dout, bus.busy, bus.done} !== 11'd0) begin
      errors++;
      $display("FAIL %s: vo=%0b dout=%0d busy=%0b done=%0b expected all 0",
               tag, bus.valid_out, bus.dout, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.bias = '0;
    bus.valid_in = 1'b0;
    bus.din = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");
  endtask

  task automatic test_basic();
    fill(256);
    done_cnt = 0;
    run_map(0, 1'b0, 1'b0);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: done pulses=%0d expected 1", done_cnt);
    end
  endtask

  task automatic test_relu_sat();
    fill(-1000);
    run_map(0, 1'b0, 1'b0);
    fill(20000);
    run_map(0, 1'b0, 1'b0);
  endtask

  task automatic test_rounding();
    int biases [3];
    biases = '{128, 127, -5};
    fill(0);
    for (int k = 0; k < 3; k++) run_map(biases[k], 1'b0, 1'b0);
  endtask

  task automatic test_pixels();
    fill(0);
    for (int p = 0; p < PIX; p++) stim[p] = (p + 1) * 256;
    run_map(0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    fill(256);
    for (int k = 0; k < 3; k++) begin
      bus.valid_in = 1'b1;
      bus.din = PSUM_W'(-30000);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    check_idle_zero_busy();
    done_cnt = 0;
    run_map(0, 1'b1, 1'b1);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignored_done: done pulses=%0d expected 1", done_cnt);
    end
  endtask

  task automatic check_idle_zero_busy();
    checks++;
    if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_in: busy=%0b vo=%0b expected 0/0",
               bus.busy, bus.valid_out);
    end
  endtask

  task automatic test_reset_midway();
    fill(256);
    bus.start = 1'b1;
    bus.bias = ACC_W'(0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.valid_in = 1'b1;
      bus.din = PSUM_W'(-77);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    run_map(0, 1'b0, 1'b0);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL reset_rerun_done: done pulses=%0d expected 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_sat();
    test_rounding();
    test_pixels();
    test_ignored();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
